// File: rtl/shift_serializer.sv
// Parallel-to-serial stage for a 74HC595-style chain. Each word is shifted out
// MSB-first on a divided serial clock, followed by a latch strobe.
module shift_serializer #(
  parameter int DATA_WIDTH = 10,
  parameter int CLK_DIV    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sdata,
  output logic                  o_sclk,
  output logic                  o_latch,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]           bitcnt_q, bitcnt_d;
  logic [DW-1:0]           divcnt_q, divcnt_d;
  logic ready_q, ready_d, sdata_q, sdata_d, sclk_q, sclk_d;
  logic latch_q, latch_d, busy_q, busy_d, done_q, done_d;
  logic phase_end;

  assign phase_end = (divcnt_q == DIV_LAST);

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q + 1'b1;
    ready_d  = ready_q;
    sdata_d  = sdata_q;
    sclk_d   = sclk_q;
    latch_d  = latch_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        sclk_d   = 1'b0;
        latch_d  = 1'b0;
        sdata_d  = 1'b0;
        divcnt_d = '0;
        if (i_valid && ready_q) begin
          shreg_d  = i_data;
          bitcnt_d = '0;
          state_d  = SETUP;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          sdata_d  = i_data[DATA_WIDTH-1];
        end
      end
      SETUP: begin
        sdata_d = shreg_q[DATA_WIDTH-1];
        if (phase_end) begin
          state_d  = HIGH;
          divcnt_d = '0;
          sclk_d   = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          divcnt_d = '0;
          sclk_d   = 1'b0;
          if (bitcnt_q == BIT_LAST) begin
            state_d = LATCH;
            sdata_d = 1'b0;
            latch_d = 1'b1;
          end else begin
            state_d  = SETUP;
            shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q + 1'b1;
            sdata_d  = shreg_q[DATA_WIDTH-2];
          end
        end
      end
      LATCH: begin
        if (phase_end) begin
          state_d  = IDLE;
          divcnt_d = '0;
          latch_d  = 1'b0;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
          done_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      ready_q  <= 1'b0;
      sdata_q  <= 1'b0;
      sclk_q   <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      ready_q  <= ready_d;
      sdata_q  <= sdata_d;
      sclk_q   <= sclk_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_ready = ready_q;
  assign o_sdata = sdata_q;
  assign o_sclk  = sclk_q;
  assign o_latch = latch_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench: W=10/DIV=2 instance for framing, back-to-back, ignore-while-busy
// and mid-frame reset; W=2/DIV=1 instance for the minimum-divider case.
`timescale 1ns/1ps
module tb_shift_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, vld = 1'b0;
  logic [9:0] dat = '0;
  logic rdy, sdo, sck, lat, bsy, dne;

  logic       r2 = 1'b1, v2 = 1'b0;
  logic [1:0] d2 = '0;
  logic rdy2, sdo2, sck2, lat2, bsy2, dne2;

  shift_serializer #(.DATA_WIDTH(10), .CLK_DIV(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_data(dat), .i_valid(vld),
    .o_ready(rdy), .o_sdata(sdo), .o_sclk(sck), .o_latch(lat), .o_busy(bsy), .o_done(dne));

  shift_serializer #(.DATA_WIDTH(2), .CLK_DIV(1)) dut2 (
    .i_clk(clk), .i_reset(r2), .i_data(d2), .i_valid(v2),
    .o_ready(rdy2), .o_sdata(sdo2), .o_sclk(sck2), .o_latch(lat2), .o_busy(bsy2), .o_done(dne2));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Negedge monitor for the main instance; ncyc=1 is the cycle after the handshake edge.
  int   ncyc = 0, hi_run = 0, lat_run = 0;
  logic sck_prev = 1'b0, lat_prev = 1'b0;
  logic bits[$];
  int   hi_lens[$], lat_lens[$], done_at[$];

  always @(negedge clk) begin
    ncyc++;
    if (sck && !sck_prev) bits.push_back(sdo);
    if (sck) hi_run++;
    else if (sck_prev) begin hi_lens.push_back(hi_run); hi_run = 0; end
    if (lat) lat_run++;
    else if (lat_prev) begin lat_lens.push_back(lat_run); lat_run = 0; end
    if (dne) done_at.push_back(ncyc);
    sck_prev = sck;
    lat_prev = lat;
  end

  task automatic clr_mon();
    ncyc = 0; hi_run = 0; lat_run = 0;
    bits.delete(); hi_lens.delete(); lat_lens.delete(); done_at.delete();
  endtask

  function automatic logic [31:0] bits_vec();
    logic [31:0] v = '0;
    foreach (bits[i]) v = {v[30:0], bits[i]};
    return v;
  endfunction

  // Handshake on the next edge, then check the first cycle of the frame.
  task automatic send(input string tag, input logic [9:0] w);
    @(negedge clk);
    #1 chk({tag, "_rdy0"}, 32'(rdy), 1);
    dat = w; vld = 1'b1;
    @(posedge clk); #1 clr_mon();
    @(negedge clk); vld = 1'b0;
    #1 chk({tag, "_c1"}, {29'd0, bsy, rdy, sdo}, {29'd0, 1'b1, 1'b0, w[9]});
  endtask

  task automatic wait_done(input string tag, input int k);
    int t = 0;
    while (done_at.size() < k && t < 400) begin @(negedge clk); #1 t++; end
    chk({tag, "_to"}, 32'(done_at.size() >= k), 1);
  endtask

  task automatic chk_frame(input string tag, input logic [9:0] w);
    int bad = 0;
    foreach (hi_lens[i]) if (hi_lens[i] != 2) bad++;
    chk({tag, "_nbits"}, 32'(bits.size()), 10);
    chk({tag, "_bits"}, bits_vec(), 32'(w));
    chk({tag, "_npulse"}, 32'(hi_lens.size()), 10);
    chk({tag, "_hiw"}, 32'(bad), 0);
    chk({tag, "_nlat"}, 32'(lat_lens.size()), 1);
    if (lat_lens.size() > 0) chk({tag, "_latw"}, 32'(lat_lens[0]), 2);
    if (done_at.size() > 0) chk({tag, "_done"}, 32'(done_at[0]), 43);
    chk({tag, "_end"}, {29'd0, rdy, dne, bsy}, {29'd0, 3'b110});
  endtask

  initial begin
    logic [5:0] sv, lv, rv, dv;
    int sck_hi, rdy_lo;

    // reset state
    repeat (3) @(negedge clk);
    #1 chk("rst_out", {26'd0, rdy, sdo, sck, lat, bsy, dne}, 0);
    rst = 1'b0;
    @(negedge clk); #1 chk("rst_rdy", 32'(rdy), 1);
    sck_hi = 0; rdy_lo = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (sck) sck_hi++;
      if (!rdy) rdy_lo++;
    end
    chk("idle_sck", 32'(sck_hi), 0);
    chk("idle_rdy", 32'(rdy_lo), 0);

    // single frame
    send("f1", 10'b1011001110);
    wait_done("f1", 1);
    chk_frame("f1", 10'b1011001110);

    // back-to-back with valid held high
    @(negedge clk);
    dat = 10'h3FF; vld = 1'b1;
    @(posedge clk); #1 clr_mon();
    @(negedge clk); dat = 10'h001;
    repeat (43) @(negedge clk);
    vld = 1'b0;
    #1 chk("b2b_c44", {30'd0, bsy, sdo}, {30'd0, 2'b10});
    wait_done("b2b", 2);
    chk("b2b_done1", 32'(done_at[0]), 43);
    chk("b2b_done2", 32'(done_at[1]), 86);
    chk("b2b_nbits", 32'(bits.size()), 20);
    chk("b2b_bits", bits_vec(), {12'd0, 10'h3FF, 10'h001});
    chk("b2b_nlat", 32'(lat_lens.size()), 2);
    repeat (5) @(negedge clk);
    #1 chk("b2b_idle", {30'd0, bsy, rdy}, {30'd0, 2'b01});

    // input changes during a frame are ignored
    send("dist", 10'h2AA);
    repeat (9) @(negedge clk);
    dat = 10'h155; vld = 1'b1;
    repeat (2) @(negedge clk);
    vld = 1'b0;
    wait_done("dist", 1);
    chk_frame("dist", 10'h2AA);
    repeat (60) @(negedge clk);
    #1 chk("dist_nodone", 32'(done_at.size()), 1);
    chk("dist_nbits", 32'(bits.size()), 10);

    // reset mid-frame
    send("mrst", 10'h3C3);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1 chk("mrst_out", {26'd0, rdy, sdo, sck, lat, bsy, dne}, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("mrst_nodone", 32'(done_at.size()), 0);
    chk("mrst_nolat", 32'(lat_lens.size()), 0);
    send("post", 10'h0F0);
    wait_done("post", 1);
    chk_frame("post", 10'h0F0);

    // minimum divider and width
    @(negedge clk); r2 = 1'b0;
    @(negedge clk); #1 chk("d1_rdy", 32'(rdy2), 1);
    d2 = 2'b10; v2 = 1'b1;
    @(posedge clk);
    sv = '0; lv = '0; rv = '0; dv = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      v2 = 1'b0;
      sv = {sv[4:0], sck2};
      lv = {lv[4:0], lat2};
      rv = {rv[4:0], rdy2};
      dv = {dv[4:0], sdo2};
    end
    chk("d1_sclk", 32'(sv), 32'b010100);
    chk("d1_latch", 32'(lv), 32'b000010);
    chk("d1_ready", 32'(rv), 32'b000001);
    chk("d1_sdata", 32'(dv), 32'b110000);
    chk("d1_done", {30'd0, dne2, bsy2}, {30'd0, 2'b10});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-to-serial output stage placed directly downstream of `shifter`. It accepts one `DATA_WIDTH`-bit word per transfer through a valid/ready handshake and clocks the word out MSB-first on a slow serial clock. It then pulses a latch strobe, which makes it suitable for driving a 74HC595-style chain behind the numeric display. The word is held in an internal shift register using shift-left-zero semantics (abcdefgh -> bcdefgh0).

## Interface

- `DATA_WIDTH`, 10, word width in bits; must be >= 2.
- `CLK_DIV`, 4, `i_clk` cycles per serial half-period; must be >= 1.

- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  reset; one clock; reset is asynchronous and active-high.
- `i_data`  in  DATA_WIDTH  word to send, normally `shifter` `o_data`.
- `i_valid`  in  1  `i_data` is valid this cycle.
- `o_ready`  out  1  block can accept a word (registered).
- `o_sdata`  out  1  serial data bit.
- `o_sclk`  out  1  serial clock; the receiver samples on the rising edge.
- `o_latch`  out  1  storage-register strobe, high after the last bit.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle pulse when a frame completes.

## Operation

- Registered state machine with states IDLE, SETUP, HIGH and LATCH.
- Internal registers:
  - `shreg` (DATA_WIDTH bits)
  - `bitcnt` (clog2(DATA_WIDTH) bits)
  - `divcnt` (clog2(CLK_DIV) bits, minimum 1 bit)
- IDLE:
  - `o_ready`=1, `o_busy`=0, `o_sclk`=0, `o_latch`=0.
  - On `i_valid` && `o_ready`: load `shreg`<=`i_data`, `bitcnt`<=0, `divcnt`<=0, and go to SETUP.
- SETUP:
  - `o_sclk`=0 and `o_sdata`=`shreg[DATA_WIDTH-1]`.
  - After CLK_DIV cycles, go to HIGH.
- HIGH:
  - `o_sclk`=1 and `o_sdata` is unchanged.
  - After CLK_DIV cycles:
    - If `bitcnt`==DATA_WIDTH-1, go to LATCH.
    - Otherwise `shreg`<=`{shreg[DATA_WIDTH-2:0],1'b0}`, `bitcnt`<=`bitcnt`+1, and go to SETUP.
- LATCH:
  - `o_latch`=1, `o_sclk`=0, `o_sdata`=0.
  - After CLK_DIV cycles, go to IDLE. `o_done` pulses for the first cycle back in IDLE.
- All outputs are registered; none is decoded combinationally from state.
- `o_busy`=1 in SETUP, HIGH and LATCH.
- `o_ready`=0 from the handshake edge until the return to IDLE.
- `i_valid` and `i_data` are ignored while busy. No word is queued, and a pending `i_valid` is accepted only once `o_ready`=1.
- `divcnt` counts 0..CLK_DIV-1 and wraps to 0 on every state change. With CLK_DIV=1 each phase lasts exactly one cycle.

## Timing

- Reset values (applied asynchronously while `i_reset`=1):
  - state=IDLE
  - `o_ready`=0, `o_sdata`=0, `o_sclk`=0, `o_latch`=0, `o_busy`=0, `o_done`=0
  - `shreg`=0, counters=0
- `o_ready` rises on the first `i_clk` edge after `i_reset` is released.
- Handshake edge = cycle 0. From cycle 1, `o_busy`=1, `o_ready`=0, and `o_sdata`=MSB.
- Bit k (k=0 is the MSB):
  - presented from cycle 1+2k·CLK_DIV;
  - `o_sclk` rises at cycle 1+(2k+1)·CLK_DIV;
  - data is stable for CLK_DIV cycles on each side of the rising edge.
- `o_latch` is high for cycles 1+2·DATA_WIDTH·CLK_DIV through 2·DATA_WIDTH·CLK_DIV+CLK_DIV.
- At cycle (2·DATA_WIDTH+1)·CLK_DIV+1:
  - `o_ready`=1, `o_done`=1, `o_busy`=0;
  - a new handshake is possible on that edge, with no idle gap required.
- Frame length from handshake to ready is (2·DATA_WIDTH+1)·CLK_DIV+1 cycles. Defaults give 85.
- Reset asserted mid-frame:
  - all outputs drop to reset values immediately;
  - no `o_done` and no `o_latch` pulse is produced;
  - the partial frame is discarded.
- `o_done` and the return of `o_ready` occur in the same cycle.

## Test plan

- Reset release, `i_valid`=0: all outputs 0 during reset; `o_ready`=1 one edge after release and held; `o_sclk` never toggles.
- DATA_WIDTH=10, CLK_DIV=2, `i_data`=10'b1011001110 with one `i_valid` pulse -> `o_sdata` at each `o_sclk` rising edge reads 1,0,1,1,0,0,1,1,1,0. Exactly 10 `o_sclk` pulses, each high 2 cycles. `o_latch` high 2 cycles. `o_done` at cycle 43.
- Back-to-back frames, `i_valid` held high, words 10'h3FF then 10'h001 -> second frame starts on the `o_done` edge. Serial stream is ten 1s, latch, then nine 0s and a 1, latch.
- `i_valid` pulses and `i_data` changes (10'h155) during a frame carrying 10'h2AA -> the frame still shifts 1010101010, and no extra frame follows.
- `i_reset` asserted at cycle 15 of a frame, then released -> `o_sclk`, `o_sdata`, `o_latch`, `o_busy` are 0 immediately with no `o_done`. The next word 10'h0F0 is sent complete and correct.
- CLK_DIV=1, DATA_WIDTH=2, `i_data`=2'b10 -> `o_sclk` pattern 0,1,0,1, then `o_latch` for 1 cycle. `o_ready` returns at cycle 6.
